// File: rtl/axis_upsizer_pkg.sv
// Shared helpers for the AXI4-Stream upsizer: index/keep widths and lane slicing.
package axis_upsizer_pkg;

  // Lane counter width; a 1:1 upsizer still carries a 1-bit index.
  function automatic int lane_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  // Byte-qualifier width for a data bus of data_w bits.
  function automatic int keep_w(input int data_w);
    return data_w / 8;
  endfunction

  // Low bit of lane 'lane' in a bus built from lanes of 'lane_bits' bits.
  function automatic int lane_lo(input int lane, input int lane_bits);
    return lane * lane_bits;
  endfunction

endpackage

// File: rtl/axis_upsizer_if.sv
// AXI4-Stream bundle; width set per instance, keep width derived.
interface axis_upsizer_if
  import axis_upsizer_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) ();
  localparam int KEEP_WIDTH = keep_w(DATA_WIDTH);

  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tlast;

  modport master (output tvalid, tdata, tkeep, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/axis_upsizer_slot.sv
// Output register of the upsizer: holds one wide beat until the sink takes it.
module axis_upsizer_slot
  import axis_upsizer_pkg::*;
#(
  parameter int M_DATA_WIDTH = 64
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          load,
  input  logic [M_DATA_WIDTH-1:0]       data,
  input  logic [keep_w(M_DATA_WIDTH)-1:0] keep,
  input  logic                          last,
  output logic                          free,
  axis_upsizer_if.master                m_axis
);

  // Slot can accept a new word when empty or being drained this edge.
  assign free = !m_axis.tvalid | m_axis.tready;

  // Load wins over drain so back-to-back words leave no bubble; payload only
  // changes on load, keeping it stable while valid is waiting on ready.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      m_axis.tvalid <= 1'b0;
      m_axis.tdata  <= '0;
      m_axis.tkeep  <= '0;
      m_axis.tlast  <= 1'b0;
    end else if (load) begin
      m_axis.tvalid <= 1'b1;
      m_axis.tdata  <= data;
      m_axis.tkeep  <= keep;
      m_axis.tlast  <= last;
    end else if (m_axis.tready) begin
      m_axis.tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_upsizer_n.sv
// AXI4-Stream upsizer: packs RATIO narrow beats (LSB first) into one wide beat.
// An early tlast closes a partial word with zeroed upper lanes. The accumulator
// doubles as a one-word skid buffer so the slave side never sees a combinational
// path from the master side.
module axis_upsizer_n
  import axis_upsizer_pkg::*;
#(
  parameter int S_DATA_WIDTH = 32,
  parameter int RATIO        = 2
) (
  input  logic           aclk,
  input  logic           areset,
  axis_upsizer_if.slave  s_axis,
  axis_upsizer_if.master m_axis
);

  localparam int M_DATA_WIDTH = S_DATA_WIDTH * RATIO;
  localparam int S_KEEP_WIDTH = keep_w(S_DATA_WIDTH);
  localparam int M_KEEP_WIDTH = keep_w(M_DATA_WIDTH);
  localparam int LW           = lane_w(RATIO);
  localparam logic [LW-1:0] LAST_LANE = LW'(RATIO - 1);

  logic [LW-1:0]                        lane_idx;
  logic                                 full;
  logic [RATIO-1:0][S_DATA_WIDTH-1:0]   acc_data;
  logic [RATIO-1:0][S_KEEP_WIDTH-1:0]   acc_keep;
  logic                                 acc_last;

  logic [M_DATA_WIDTH-1:0] word_data;
  logic [M_KEEP_WIDTH-1:0] word_keep;
  logic                    accept, complete, slot_free, load;
  logic [M_DATA_WIDTH-1:0] load_data;
  logic [M_KEEP_WIDTH-1:0] load_keep;
  logic                    load_last;

  // Ready depends only on state; held low while reset is asserted.
  assign s_axis.tready = !full & !areset;
  assign accept        = s_axis.tvalid & s_axis.tready;
  assign complete      = accept & ((lane_idx == LAST_LANE) | s_axis.tlast);

  // Word as it would look if the current beat completed it: lanes below the
  // index come from the accumulator, the current lane from the input, lanes
  // above are zero so leftovers from earlier words never leak out.
  for (genvar l = 0; l < RATIO; l++) begin : g_lane
    assign word_data[lane_lo(l, S_DATA_WIDTH) +: S_DATA_WIDTH] =
      (lane_idx == LW'(l)) ? s_axis.tdata :
      (LW'(l) < lane_idx)  ? acc_data[l]  : '0;
    assign word_keep[lane_lo(l, S_KEEP_WIDTH) +: S_KEEP_WIDTH] =
      (lane_idx == LW'(l)) ? s_axis.tkeep :
      (LW'(l) < lane_idx)  ? acc_keep[l]  : '0;
  end

  // A parked word always goes first; otherwise a completing beat goes straight out.
  assign load      = slot_free & (full | complete);
  assign load_data = full ? acc_data : word_data;
  assign load_keep = full ? acc_keep : word_keep;
  assign load_last = full ? acc_last : s_axis.tlast;

  // Lane counter and parked-word flag.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      lane_idx <= '0;
      full     <= 1'b0;
    end else begin
      if (accept) lane_idx <= complete ? '0 : lane_idx + LW'(1);
      if (full & slot_free)           full <= 1'b0;
      else if (complete & !slot_free) full <= 1'b1;
    end
  end

  // Accumulator: collects lanes, or parks a whole word while the slot is busy.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      acc_data <= '0;
      acc_keep <= '0;
      acc_last <= 1'b0;
    end else if (complete & !slot_free) begin
      acc_data <= word_data;
      acc_keep <= word_keep;
      acc_last <= s_axis.tlast;
    end else if (accept & !complete) begin
      acc_data[lane_idx] <= s_axis.tdata;
      acc_keep[lane_idx] <= s_axis.tkeep;
    end
  end

  axis_upsizer_slot #(.M_DATA_WIDTH(M_DATA_WIDTH)) u_slot (
    .aclk   (aclk),
    .areset (areset),
    .load   (load),
    .data   (load_data),
    .keep   (load_keep),
    .last   (load_last),
    .free   (slot_free),
    .m_axis (m_axis)
  );

endmodule

// File: doc/axis_upsizer_n.md
# axis_upsizer_n

Parametrised AXI4-Stream width upsizer: packs RATIO narrow slave beats into one wide master beat. Successor to the fixed 2:1 upsizer, adding arbitrary ratio, tkeep, tlast-terminated partial words and full-throughput double buffering. Sits between narrow producers (DMA, ADC framers) and wide datapath or memory stages.

## Interface

- S_DATA_WIDTH, 32, slave data width in bits; multiple of 8.
- RATIO, 2, slave beats per master beat; ≥1.
- M_DATA_WIDTH, derived localparam = S_DATA_WIDTH*RATIO; S_KEEP_WIDTH = S_DATA_WIDTH/8; M_KEEP_WIDTH = M_DATA_WIDTH/8.

- aclk  in  1  clock; all logic on its rising edge.
- areset  in  1  reset, asynchronous and active-high.
- s_axis_tvalid  in  1  slave beat valid.
- s_axis_tready  out  1  slave ready.
- s_axis_tdata  in  S_DATA_WIDTH  slave data.
- s_axis_tkeep  in  S_KEEP_WIDTH  slave byte qualifiers.
- s_axis_tlast  in  1  packet end.
- m_axis_tvalid  out  1  master beat valid.
- m_axis_tready  in  1  master ready.
- m_axis_tdata  out  M_DATA_WIDTH  packed data.
- m_axis_tkeep  out  M_KEEP_WIDTH  packed byte qualifiers.
- m_axis_tlast  out  1  packet end.

## Operation

- Lane counter lane_idx, 0..RATIO-1, width max(1,$clog2(RATIO)). Beat accepted (s_tvalid & s_tready) at lane k writes tdata to accumulator bits [k*S +: S], tkeep to keep bits [k*S/8 +: S/8].
- Little-endian packing: first beat of a word occupies LSBs.
- Completing beat: lane_idx == RATIO-1, or s_axis_tlast = 1 at any lane. lane_idx returns to 0; next beat always starts lane 0.
- Partial word (tlast before last lane): unfilled lanes tdata = 0, tkeep = 0; m_axis_tlast = 1.
- Non-completing beats: lane_idx increments; accumulator updated.
- Output slot = master register (tdata/tkeep/tlast/tvalid). Slot free = !m_axis_tvalid | m_axis_tready.
- Completing beat with slot free: word (accumulator lanes + incoming beat) loads slot same edge.
- Completing beat with slot busy: word held in accumulator, full = 1.
- full = 1 and slot free: accumulator loads slot, full clears same edge.
- s_axis_tready = !full (state-only, no combinational path from m_axis_tready or s_axis_tvalid).
- Null beats (tkeep = 0) packed like any other beat; no filtering.
- RATIO = 1: every beat is completing; block is a registered slice with one-entry skid (full).

## Timing

- Reset values: m_axis_tvalid 0, m_axis_tdata 0, m_axis_tkeep 0, m_axis_tlast 0, s_axis_tready 0 while areset high; lane_idx 0, full 0, accumulator cleared. s_axis_tready = 1 first cycle after areset deasserts.
- Reset mid-word: partially packed lanes discarded; no output emitted for them.
- Latency: completing beat accepted at edge n -> m_axis_tvalid high after edge n (one cycle).
- Throughput: one slave beat per cycle sustained while m_axis_tready = 1; one master beat every RATIO cycles (fewer with early tlast).
- m_axis_tvalid once high stays high with stable tdata/tkeep/tlast until m_axis_tready sampled high.
- Simultaneous: slot drained and new completing beat same edge -> slot reloads, m_axis_tvalid stays high, no bubble.
- Backpressure: full set at edge n; s_axis_tready low from edge n until the edge after slot frees.

## Structure

- Package axis_upsizer_pkg: lane-index width function, keep-width helper, lane slice helper.
- One sub-module: axis_upsizer_slot (output register + valid/ready handling), parametrised on M_DATA_WIDTH.
- Top holds lane counter, accumulator, full flag.

## Test plan

- S=32, RATIO=2, data 0x64,0x74,0x84,0x94, tkeep 0xF, m_tready=1 -> m_tdata 0x00000074_00000064 then 0x00000094_00000084, m_tkeep 0xFF, s_tready constant 1.
- RATIO=4, beats A,B,C with tlast on C -> m_tdata {0,C,B,A}, m_tkeep 0x0FFF, m_tlast 1; next beat D lands in lane 0.
- RATIO=2, m_tready=0, send 4 beats -> first word in slot, second in accumulator, s_tready low after 4th; raise m_tready -> both words in order, s_tready high the cycle after.
- One beat accepted, areset pulse -> all outputs at reset values; next beats start lane 0, stale lane never appears.
- RATIO ∈ {1,3,8}, random tvalid/tready/tlast, 2000 beats -> scoreboard matches packed stream, no loss/duplication, AXIS stability assertions pass.
